// File: rtl/mem_dump_axi_pkg.sv
// rtl/mem_dump_axi_pkg.sv - shared FSM state, AXI constants and helpers for the memory dump engine
package mem_dump_axi_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [31:0] BOUNDARY_4K    = 32'h0000_1000;

  // Memory is little-endian; the consumer wants file byte order.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mem_dump_burst_calc.sv
// rtl/mem_dump_burst_calc.sv - burst length L = min(max beats, words remaining, words to next 4 KB page)
module mem_dump_burst_calc
  import mem_dump_axi_pkg::*;
#(
  parameter int unsigned P_BURST_MAX = 16
) (
  input  logic [9:0]  word_in_page_i,
  input  logic [31:0] remaining_i,
  output logic [8:0]  len_o
);

  localparam logic [8:0] BURST_MAX_9 = 9'(P_BURST_MAX);

  logic [10:0] to_boundary;
  logic [8:0]  len_clip;

  always_comb begin
    to_boundary = 11'(BOUNDARY_4K >> 2) - {1'b0, word_in_page_i};
    len_clip    = BURST_MAX_9;
    if (remaining_i < 32'(P_BURST_MAX)) len_clip = remaining_i[8:0];
    if (to_boundary < {2'b00, len_clip}) len_clip = to_boundary[8:0];
  end

  assign len_o = len_clip;

endmodule

// File: rtl/mem_dump_axi.sv
// rtl/mem_dump_axi.sv - AXI4 read master streaming a memory region out as byte-swapped 32-bit words
module mem_dump_axi
  import mem_dump_axi_pkg::*;
#(
  parameter int unsigned P_BURST_MAX  = 16,
  parameter int unsigned AXI_WIDTH_ID = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start,
  input  logic [31:0]             addr_base,
  input  logic [31:0]             num_words,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [AXI_WIDTH_ID-1:0] m_arid,
  output logic [31:0]             m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [AXI_WIDTH_ID-1:0] m_rid,
  input  logic [31:0]             m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic [31:0]             out_data,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] out_data_q, out_data_d;
  logic [8:0]  beat_q, beat_d;
  logic [8:0]  blen_q, blen_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic        error_q, error_d;
  logic [8:0]  calc_len;
  logic        ar_fire, r_fire, burst_end;
  logic        unused_inputs;

  mem_dump_burst_calc #(.P_BURST_MAX(P_BURST_MAX)) u_burst_calc (
    .word_in_page_i (addr_q[11:2]),
    .remaining_i    (remaining_q),
    .len_o          (calc_len)
  );

  assign unused_inputs = ^{m_rid, addr_base[1:0]};

  assign m_arvalid = (state_q == S_ADDR);
  assign m_arid    = '0;
  assign m_araddr  = addr_q;
  assign m_arlen   = m_arvalid ? 8'(calc_len - 9'd1) : 8'd0;
  assign m_arsize  = AXI_SIZE_4B;
  assign m_arburst = AXI_BURST_INCR;
  assign m_rready  = (state_q == S_DATA) && (!out_valid_q || out_ready);

  assign ar_fire   = m_arvalid && m_arready;
  assign r_fire    = m_rvalid && m_rready;
  assign burst_end = (beat_q + 9'd1 == blen_q);

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE) && !out_valid_q;
  assign error     = error_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    beat_d      = beat_q;
    blen_d      = blen_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    error_d     = error_q;

    // Consumer drain first so a same-cycle load below takes priority.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = {addr_base[31:2], 2'b00};
          remaining_d = num_words;
          error_d     = 1'b0;
          state_d     = (num_words == 32'd0) ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: begin
        if (ar_fire) begin
          blen_d  = calc_len;
          beat_d  = 9'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (r_fire) begin
          out_data_d  = byte_swap32(m_rdata);
          out_valid_d = 1'b1;
          out_last_d  = (remaining_q == 32'd1);
          if (remaining_q != 32'd0) remaining_d = remaining_q - 32'd1;
          addr_d = addr_q + 32'd4;
          beat_d = beat_q + 9'd1;
          if ((m_rresp != AXI_RESP_OKAY) || (m_rlast != burst_end)) error_d = 1'b1;
          if (burst_end) state_d = (remaining_q > 32'd1) ? S_ADDR : S_DONE;
        end
      end
      S_DONE: begin
        if (!out_valid_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      beat_q      <= '0;
      blen_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      beat_q      <= beat_d;
      blen_q      <= blen_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_mem_dump_axi.sv
// tb/tb_mem_dump_axi.sv - scoreboard bench for mem_dump_axi with a randomized AXI slave and consumer
module tb_mem_dump_axi;

  localparam int BMAX = 16;
  localparam int IDW  = 4;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic           start = 1'b0;
  logic [31:0]    addr_base = '0;
  logic [31:0]    num_words = '0;
  logic           busy, done, error;
  logic [IDW-1:0] m_arid;
  logic [31:0]    m_araddr;
  logic [7:0]     m_arlen;
  logic [2:0]     m_arsize;
  logic [1:0]     m_arburst;
  logic           m_arvalid;
  logic           m_arready;
  logic [IDW-1:0] m_rid;
  logic [31:0]    m_rdata;
  logic [1:0]     m_rresp;
  logic           m_rlast;
  logic           m_rvalid;
  logic           m_rready;
  logic [31:0]    out_data;
  logic           out_valid;
  logic           out_last;
  logic           out_ready;

  mem_dump_axi #(.P_BURST_MAX(BMAX), .AXI_WIDTH_ID(IDW)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .addr_base(addr_base), .num_words(num_words),
    .busy(busy), .done(done), .error(error),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Memory contents as seen by the slave; one address can be overridden.
  bit          ovr_en = 0;
  logic [31:0] ovr_addr = '0;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr_en && a == ovr_addr) return 32'h1122_3344;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] file_order(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
    return r;
  endfunction

  logic [32:0] exp_out_q[$];
  logic [39:0] exp_ar_q[$];
  int          done_cnt = 0;
  int          words_seen = 0;
  bit          first_pending = 0;
  logic [31:0] first_word = '0;

  // Slave state
  bit          b_act = 0;
  logic [31:0] b_addr = '0;
  int          b_len = 0;
  int          b_idx = 0;
  int          word_idx = 0;
  int          err_beat = -1;
  bit          drop_last = 0;
  bit          r_fired = 0;
  int          ready_mode = 0;

  initial begin
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rid = '0;
    forever begin
      @(negedge aclk);
      m_arready = !b_act && ($urandom_range(0, 3) != 0);
      if (b_act) begin
        if (!m_rvalid || r_fired) m_rvalid = ($urandom_range(0, 3) != 0);
        m_rdata = mem_word(b_addr + 32'(4 * b_idx));
        m_rresp = (word_idx == err_beat) ? 2'b10 : 2'b00;
        m_rlast = (b_idx == b_len - 1) && !drop_last;
      end else begin
        m_rvalid = 0;
      end
      r_fired = 0;
      #2;
      if (!aresetn) begin
        b_act = 0; m_rvalid = 0; m_arready = 0;
      end else if (m_arvalid && m_arready) begin
        b_act = 1; b_addr = m_araddr; b_len = int'(m_arlen) + 1; b_idx = 0;
      end else if (m_rvalid && m_rready) begin
        r_fired = 1; b_idx++; word_idx++;
        if (b_idx == b_len) b_act = 0;
      end
    end
  end

  initial begin
    out_ready = 1;
    forever begin
      @(negedge aclk);
      case (ready_mode)
        0:       out_ready = 1;
        1:       out_ready = !out_ready;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: compares DUT activity against the queued expectations.
  initial begin
    logic [32:0] eo;
    logic [39:0] ea;
    forever begin
      @(negedge aclk);
      #3;
      if (aresetn) begin
        if (out_valid && out_ready) begin
          check_eq("out_expected", 32'(exp_out_q.size() != 0), 32'd1);
          if (exp_out_q.size() != 0) begin
            eo = exp_out_q.pop_front();
            check_eq("out_data", out_data, eo[31:0]);
            check_eq("out_last", 32'(out_last), 32'(eo[32]));
            if (first_pending) begin first_word = out_data; first_pending = 0; end
            words_seen++;
          end
        end
        if (out_valid && !out_ready) check_eq("rready_backpressure", 32'(m_rready), 32'd0);
        if (m_arvalid && m_arready) begin
          check_eq("ar_expected", 32'(exp_ar_q.size() != 0), 32'd1);
          if (exp_ar_q.size() != 0) begin
            ea = exp_ar_q.pop_front();
            check_eq("araddr", m_araddr, ea[31:0]);
            check_eq("arlen", 32'(m_arlen), 32'(ea[39:32]));
            check_eq("arsize_burst_id", {m_arid, 21'd0, m_arsize, m_arburst}, {4'd0, 21'd0, 3'b010, 2'b01});
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic dump(input logic [31:0] base, input int n, input int mode, input int err,
                      input bit drop, input bit poke, input bit exp_err);
    logic [31:0] a, a2;
    int rem, room, l;
    word_idx = 0; err_beat = err; drop_last = drop; ready_mode = mode;
    a = {base[31:2], 2'b00};
    for (int i = 0; i < n; i++)
      exp_out_q.push_back({(i == n - 1), file_order(mem_word(a + 32'(4 * i)))});
    rem = n; a2 = a;
    while (rem > 0) begin
      room = (4096 - int'(a2[11:0])) / 4;
      l = BMAX;
      if (rem < l) l = rem;
      if (room < l) l = room;
      exp_ar_q.push_back({8'(l - 1), a2});
      a2 = a2 + 32'(4 * l);
      rem -= l;
    end
    done_cnt = 0; words_seen = 0; first_pending = 1;
    @(negedge aclk);
    start = 1; addr_base = base; num_words = n;
    @(negedge aclk);
    start = 0;
    #4;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    if (n == 0) begin
      check_eq("zero_done_next_cycle", 32'(done), 32'd1);
      check_eq("zero_error_cleared", 32'(error), 32'd0);
    end
    for (int cyc = 0; cyc < 5000 && done_cnt == 0; cyc++) begin
      @(negedge aclk);
      if (poke && cyc == 10) begin start = 1; addr_base = 32'hDEAD_0000; num_words = 3; end
      else start = 0;
    end
    start = 0;
    repeat (3) @(negedge aclk);
    #4;
    check_eq("done_once", 32'(done_cnt), 32'd1);
    check_eq("idle_after_done", 32'(busy), 32'd0);
    check_eq("error_flag", 32'(error), 32'(exp_err));
    check_eq("words_delivered", 32'(words_seen), 32'(n));
    check_eq("out_queue_empty", 32'(exp_out_q.size()), 32'd0);
    check_eq("ar_queue_empty", 32'(exp_ar_q.size()), 32'd0);
    exp_out_q.delete(); exp_ar_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctl"}, {24'd0, m_arvalid, m_rready, out_valid, out_last, busy, done, error, 1'b0}, 32'd0);
    check_eq({tag, "_out_data"}, out_data, 32'd0);
    check_eq({tag, "_araddr"}, m_araddr, 32'd0);
    check_eq({tag, "_arlen"}, 32'(m_arlen), 32'd0);
  endtask

  initial begin
    int n, mode;
    logic [31:0] base;
    repeat (3) @(negedge aclk);
    #1 check_reset_outputs("reset");
    aresetn = 1;
    repeat (2) @(negedge aclk);

    dump(32'h0000_0000, 40, 0, -1, 0, 0, 0);
    dump(32'h0000_0FF0,  8, 2, -1, 0, 0, 0);
    ovr_en = 1; ovr_addr = 32'h0000_2000;
    dump(32'h0000_2003,  5, 0, -1, 0, 0, 0);
    check_eq("swap_first_word", first_word, 32'h4433_2211);
    ovr_en = 0;
    dump(32'h0000_0100, 20, 1, -1, 0, 0, 0);
    dump(32'h0000_0300,  5, 2,  2, 0, 0, 1);
    dump(32'h0000_0400,  0, 0, -1, 0, 0, 0);
    dump(32'h0000_0500, 20, 0, -1, 1, 0, 1);
    dump(32'hFFFF_FFF0,  8, 2, -1, 0, 0, 0);
    dump(32'h0000_4000, 40, 2, -1, 0, 1, 0);
    for (int t = 0; t < 6; t++) begin
      base = $urandom();
      n    = $urandom_range(1, 70);
      mode = $urandom_range(0, 2);
      dump(base, n, mode, -1, 0, 0, 0);
    end

    // Abandon a dump mid-burst with error already set.
    word_idx = 0; err_beat = 1; drop_last = 0; ready_mode = 0; words_seen = 0;
    for (int i = 0; i < 30; i++)
      exp_out_q.push_back({(i == 29), file_order(mem_word(32'h0000_6000 + 32'(4 * i)))});
    exp_ar_q.push_back({8'd15, 32'h0000_6000});
    @(negedge aclk);
    start = 1; addr_base = 32'h0000_6000; num_words = 30;
    @(negedge aclk);
    start = 0;
    for (int cyc = 0; cyc < 500 && words_seen < 3; cyc++) @(negedge aclk);
    check_eq("pre_reset_error", 32'(error), 32'd1);
    aresetn = 0;
    #1 check_reset_outputs("midreset");
    exp_out_q.delete(); exp_ar_q.delete();
    repeat (3) @(negedge aclk);
    aresetn = 1;
    dump(32'h0000_7000, 24, 2, -1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
